cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Completion-stage writer for the 64x32 physical register file: collects finished results from NUM_FU
//  functional units, buffers each in a small per-unit queue, and grants one result per cycle to the CDB.
//  Winner drives PRF write port (p_rd / wr_data_in / RegDest_compl) and the tag broadcast to RS/ROB.
//  CDB outputs are registered and held stable for a whole clk cycle, as the PRF's half-cycle write requires.
// PARAMETERS
//  NUM_FU     3   functional units (0=ALU, 1=MUL, 2=LD/ST); one request port each
//  TAG_W      6   physical register tag width (64 PRF entries)
//  DATA_W     32  result width
//  ROB_W      5   ROB index width
//  QDEPTH     2   per-FU queue depth (power of 2, >=2)
// PORTS
//  clk           in   1               core clock, all state on rising edge
//  rst           in   1               asynchronous, active-low reset
//  flush         in   1               mispredict flush: drop all queued/registered results
//  fu_valid      in   NUM_FU          FU i presents a completed result
//  fu_ready      out  NUM_FU          FU i queue can accept this cycle
//  fu_tag        in   NUM_FU*TAG_W    dest phys reg per FU (slice i)
//  fu_data       in   NUM_FU*DATA_W   result value per FU
//  fu_regdest    in   NUM_FU          1 = instruction writes a register
//  fu_rob_idx    in   NUM_FU*ROB_W    ROB entry per FU
//  cdb_valid     out  1               broadcast valid (ROB marks complete)
//  p_rd          out  TAG_W           CDB.Tag -> PRF write address, RS wakeup tag
//  wr_data_in    out  DATA_W          CDB.Value -> PRF write data, RS operand capture
//  RegDest_compl out  1               = cdb_valid & winner's regdest; PRF write enable
//  cdb_rob_idx   out  ROB_W           ROB entry being completed
// BEHAVIOUR
//  - Reset (rst low, async): all queues empty, rr_ptr=0, cdb_valid=0, RegDest_compl=0, p_rd=0,
//    wr_data_in=0, cdb_rob_idx=0; fu_ready=all-ones once rst deasserts.
//  - fu_ready[i] = queue i not full, from registered count only (no same-cycle pop credit).
//  - Push: fu_valid[i]&fu_ready[i] at edge -> entry {tag,data,regdest,rob} enqueued in order.
//    fu_valid while !fu_ready: ignored, FU must hold it (no drop, no overwrite).
//  - Arbitration each cycle over non-empty queues (pre-push state): round-robin starting at rr_ptr;
//    winner w popped at edge, its head registered onto CDB outputs; rr_ptr <= (w+1) mod NUM_FU.
//    No requester: cdb_valid<=0, RegDest_compl<=0, rr_ptr unchanged, tag/data hold last value.
//  - Latency: fu_valid in cycle c, queue empty, no contention -> cdb_valid in cycle c+2, one cycle wide.
//  - Throughput: 1 result/cycle total; a queue simultaneously pushed and popped keeps its count.
//  - regdest=0 entries (stores, branches): cdb_valid=1, RegDest_compl=0 (ROB completes, no PRF write).
//  - Tag 0 with regdest=1 is written normally; no special-casing.
//  - flush at edge: all queues emptied, cdb_valid/RegDest_compl <= 0, rr_ptr kept; pushes and
//    arbitration in the flush cycle discarded. fu_ready stays 1 throughout.
//  - Queue pointers wrap mod QDEPTH; count width clog2(QDEPTH)+1 distinguishes full from empty.
//  - rst asserted mid-operation: everything returns to reset values immediately, results lost.
// STRUCTURE
//  - Shared defs include (ooo_defs.vh): TAG_W, DATA_W, ROB_W, FU index localparams (FU_ALU/MUL/LDST),
//    CDB entry field offsets; shared with reservation stations, ROB, PRF.
//  - Sub-module cdb_fifo: parameterised QDEPTH sync FIFO (push/pop/flush, full/empty, head data),
//    instantiated NUM_FU times via generate; arbiter + output regs in this module.
// TESTING
//  1 Reset: rst low mid-traffic -> all outputs 0 same cycle; after release fu_ready=3'b111.
//  2 Single ALU result tag=6'd12 data=32'hDEADBEEF regdest=1 rob=5 in cycle 1 -> cycle 3:
//    cdb_valid=1, RegDest_compl=1, p_rd=12, wr_data_in=DEADBEEF, cdb_rob_idx=5; cycle 4 valid=0.
//  3 All three FUs valid same cycle, rr_ptr=0 -> CDB order FU0,FU1,FU2 on consecutive cycles;
//    next simultaneous burst starts at FU0 again (rr_ptr wrapped to 0 after FU2).
//  4 MUL held valid 4 cycles with FU0 saturating -> fu_ready[1] drops after 2 accepts, no loss,
//    no duplicates; every tag appears exactly once on p_rd.
//  5 Store completion regdest=0 rob=9 -> cdb_valid=1, cdb_rob_idx=9, RegDest_compl=0.
//  6 flush with 2 entries queued in FU2 and a result on CDB -> next cycle cdb_valid=0,
//    none of the flushed tags ever appear; new push after flush emerges 2 cycles later.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-stage definitions: widths, FU indices, queued CDB entry layout
// and the round-robin pick helper used by the arbiter.
package cdb_arbiter_pkg;

    localparam int NUM_FU = 3;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 5;
    localparam int QDEPTH = 2;
    localparam int FU_W   = $clog2(NUM_FU);

    typedef enum logic [FU_W-1:0] {
        FU_ALU  = 2'd0,
        FU_MUL  = 2'd1,
        FU_LDST = 2'd2
    } fu_id_e;

    typedef struct packed {
        logic              regdest;
        logic [ROB_W-1:0]  rob;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic            found;
        logic [FU_W-1:0] idx;
    } rr_pick_t;

    // Scanned from the far end so the requester closest to ptr is the last one assigned.
    function automatic rr_pick_t rr_pick(input logic [NUM_FU-1:0] req, input logic [FU_W-1:0] ptr);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_FU) c = c - NUM_FU;
            if (req[c]) begin
                r.found = 1'b1;
                r.idx   = FU_W'(c);
            end
        end
        return r;
    endfunction

    function automatic logic [FU_W-1:0] rr_next(input logic [FU_W-1:0] idx);
        return (idx == FU_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small in-order result queue for one functional unit; flush empties it and
// discards any same-cycle push or pop.
module cdb_arbiter_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output cdb_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    cdb_entry_t    mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-stage CDB writer: per-FU result queues, round-robin grant of one
// result per cycle, registered broadcast to PRF write port, RS and ROB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    output logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    input  logic [NUM_FU-1:0]          fu_regdest,
    input  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           p_rd,
    output logic [DATA_W-1:0]          wr_data_in,
    output logic                       RegDest_compl,
    output logic [ROB_W-1:0]           cdb_rob_idx
);

    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    cdb_entry_t        din  [NUM_FU];
    cdb_entry_t        head [NUM_FU];
    logic [FU_W-1:0]   rr_ptr;
    rr_pick_t          pick;

    // Readiness comes from the registered count only, so a full queue stalls its FU
    // even in a cycle where that queue is also being popped.
    assign fu_ready = ~full;
    assign push     = fu_valid & ~full;
    assign pick     = rr_pick(~empty, rr_ptr);

    always_comb begin
        pop = '0;
        if (pick.found) pop[pick.idx] = 1'b1;
    end

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        assign din[gi] = '{
            regdest: fu_regdest[gi],
            rob:     fu_rob_idx[gi*ROB_W +: ROB_W],
            tag:     fu_tag[gi*TAG_W +: TAG_W],
            data:    fu_data[gi*DATA_W +: DATA_W]
        };

        cdb_arbiter_fifo #(.DEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .din   (din[gi]),
            .head  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    // Broadcast register: tag/data hold their last value when idle so the PRF sees a stable word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr        <= '0;
            cdb_valid     <= 1'b0;
            RegDest_compl <= 1'b0;
            p_rd          <= '0;
            wr_data_in    <= '0;
            cdb_rob_idx   <= '0;
        end else if (flush) begin
            cdb_valid     <= 1'b0;
            RegDest_compl <= 1'b0;
        end else if (pick.found) begin
            cdb_valid     <= 1'b1;
            RegDest_compl <= head[pick.idx].regdest;
            p_rd          <= head[pick.idx].tag;
            wr_data_in    <= head[pick.idx].data;
            cdb_rob_idx   <= head[pick.idx].rob;
            rr_ptr        <= rr_next(pick.idx);
        end else begin
            cdb_valid     <= 1'b0;
            RegDest_compl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: reset, latency, round-robin order,
// back-pressure, store completion, flush and mid-run reset.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   fu_valid = '0;
    logic [2:0]   fu_ready;
    logic [17:0]  fu_tag = '0;
    logic [95:0]  fu_data = '0;
    logic [2:0]   fu_regdest = '0;
    logic [14:0]  fu_rob_idx = '0;
    logic         cdb_valid;
    logic [5:0]   p_rd;
    logic [31:0]  wr_data_in;
    logic         RegDest_compl;
    logic [4:0]   cdb_rob_idx;
    logic [44:0]  cdb_all;

    int n_vec = 0;
    int n_bad = 0;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_tag        (fu_tag),
        .fu_data       (fu_data),
        .fu_regdest    (fu_regdest),
        .fu_rob_idx    (fu_rob_idx),
        .cdb_valid     (cdb_valid),
        .p_rd          (p_rd),
        .wr_data_in    (wr_data_in),
        .RegDest_compl (RegDest_compl),
        .cdb_rob_idx   (cdb_rob_idx)
    );

    assign cdb_all = {cdb_valid, RegDest_compl, p_rd, wr_data_in, cdb_rob_idx};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [5:0] tag,
                          input logic [31:0] data, input logic rd, input logic [4:0] rob);
        fu_valid[i]           = v;
        fu_tag[i*6 +: 6]      = tag;
        fu_data[i*32 +: 32]   = data;
        fu_regdest[i]         = rd;
        fu_rob_idx[i*5 +: 5]  = rob;
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if (cdb_all !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_cdb: got %h want 0", cdb_all);
        end
        #10 rst = 1'b1;
        #1;
        n_vec++;
        if (fu_ready !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 111", fu_ready);
        end
        tick();
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_valid: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_burst;
        logic [44:0] exp;
        for (int k = 1; k <= 3; k++) set_fu(k - 1, 1'b1, 6'(k), 32'hA0 + 32'(k), 1'b1, 5'(k));
        tick();
        fu_valid = '0;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_latency: valid %b want 0", cdb_valid);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = {2'b11, 6'(k), 32'hA0 + 32'(k), 5'(k)};
            n_vec++;
            if (cdb_all !== exp) begin
                n_bad++;
                $display("FAIL burst1_slot%0d: got %h want %h", k, cdb_all, exp);
            end
        end
        for (int k = 4; k <= 6; k++) set_fu(k - 4, 1'b1, 6'(k), 32'hB0 + 32'(k), 1'b1, 5'(k));
        tick();
        fu_valid = '0;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL burst2_latency: valid %b want 0", cdb_valid);
        end
        for (int k = 4; k <= 6; k++) begin
            tick();
            exp = {2'b11, 6'(k), 32'hB0 + 32'(k), 5'(k)};
            n_vec++;
            if (cdb_all !== exp) begin
                n_bad++;
                $display("FAIL burst2_slot%0d: got %h want %h", k, cdb_all, exp);
            end
        end
        tick();
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_drain: valid %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single;
        set_fu(0, 1'b1, 6'd12, 32'hDEADBEEF, 1'b1, 5'd5);
        tick();
        fu_valid = '0;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_c2: valid %b want 0", cdb_valid);
        end
        tick();
        n_vec++;
        if (cdb_all !== {2'b11, 6'd12, 32'hDEADBEEF, 5'd5}) begin
            n_bad++;
            $display("FAIL single_c3: got %h want %h", cdb_all, {2'b11, 6'd12, 32'hDEADBEEF, 5'd5});
        end
        tick();
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_c4: valid %b want 0", cdb_valid);
        end
    endtask

    task automatic test_store;
        set_fu(2, 1'b1, 6'd7, 32'h5, 1'b0, 5'd9);
        tick();
        fu_valid = '0;
        tick();
        n_vec++;
        if ({cdb_valid, RegDest_compl, cdb_rob_idx} !== {1'b1, 1'b0, 5'd9}) begin
            n_bad++;
            $display("FAIL store: got v=%b rd=%b rob=%0d want v=1 rd=0 rob=9",
                     cdb_valid, RegDest_compl, cdb_rob_idx);
        end
        tick();
        n_vec++;
        if ({cdb_valid, RegDest_compl} !== 2'b00) begin
            n_bad++;
            $display("FAIL store_after: got v=%b rd=%b want 00", cdb_valid, RegDest_compl);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_rdy [10] = '{3'b111, 3'b111, 3'b101, 3'b110, 3'b101,
                                     3'b110, 3'b101, 3'b111, 3'b111, 3'b111};
        int exp_tag [10] = '{-1, 10, 20, 11, 21, 12, 22, 13, 23, -1};
        int a0 = 0;
        int a1 = 0;
        logic acc0, acc1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            set_fu(0, a0 < 4, 6'(10 + a0), 32'h100 + 32'(a0), 1'b1, 5'(a0));
            set_fu(1, a1 < 4, 6'(20 + a1), 32'h200 + 32'(a1), 1'b1, 5'(a1));
            n_vec++;
            if (fu_ready !== exp_rdy[cyc]) begin
                n_bad++;
                $display("FAIL b2b_ready_c%0d: got %b want %b", cyc, fu_ready, exp_rdy[cyc]);
            end
            acc0 = fu_valid[0] & fu_ready[0];
            acc1 = fu_valid[1] & fu_ready[1];
            tick();
            if (acc0) a0++;
            if (acc1) a1++;
            n_vec++;
            if (exp_tag[cyc] < 0) begin
                if (cdb_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_out_c%0d: valid %b tag %0d want idle", cyc, cdb_valid, p_rd);
                end
            end else if ({cdb_valid, p_rd} !== {1'b1, 6'(exp_tag[cyc])}) begin
                n_bad++;
                $display("FAIL b2b_out_c%0d: valid %b tag %0d want tag %0d", cyc, cdb_valid, p_rd, exp_tag[cyc]);
            end
        end
        fu_valid = '0;
    endtask

    task automatic test_flush;
        set_fu(0, 1'b1, 6'd40, 32'h40, 1'b1, 5'd0);
        set_fu(1, 1'b1, 6'd41, 32'h41, 1'b1, 5'd1);
        tick();
        fu_valid = '0;
        set_fu(2, 1'b1, 6'd30, 32'h30, 1'b1, 5'd2);
        tick();
        n_vec++;
        if ({cdb_valid, p_rd} !== {1'b1, 6'd40}) begin
            n_bad++;
            $display("FAIL flush_pre1: valid %b tag %0d want tag 40", cdb_valid, p_rd);
        end
        set_fu(2, 1'b1, 6'd31, 32'h31, 1'b1, 5'd3);
        tick();
        fu_valid = '0;
        n_vec++;
        if ({cdb_valid, p_rd} !== {1'b1, 6'd41}) begin
            n_bad++;
            $display("FAIL flush_pre2: valid %b tag %0d want tag 41", cdb_valid, p_rd);
        end
        flush = 1'b1;
        set_fu(0, 1'b1, 6'd42, 32'h42, 1'b1, 5'd4);
        tick();
        flush = 1'b0;
        fu_valid = '0;
        n_vec++;
        if ({cdb_valid, RegDest_compl} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_cdb: got v=%b rd=%b want 00", cdb_valid, RegDest_compl);
        end
        n_vec++;
        if (fu_ready !== 3'b111) begin
            n_bad++;
            $display("FAIL flush_ready: got %b want 111", fu_ready);
        end
        set_fu(1, 1'b1, 6'd50, 32'h50, 1'b1, 5'd6);
        tick();
        fu_valid = '0;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_post1: valid %b tag %0d want idle", cdb_valid, p_rd);
        end
        tick();
        n_vec++;
        if ({cdb_valid, p_rd, cdb_rob_idx} !== {1'b1, 6'd50, 5'd6}) begin
            n_bad++;
            $display("FAIL flush_newpush: valid %b tag %0d rob %0d want tag 50 rob 6", cdb_valid, p_rd, cdb_rob_idx);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (cdb_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_drained%0d: valid %b tag %0d want idle", k, cdb_valid, p_rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        set_fu(0, 1'b1, 6'd60, 32'h60, 1'b1, 5'd7);
        set_fu(1, 1'b1, 6'd61, 32'h61, 1'b1, 5'd8);
        tick();
        fu_valid = '0;
        tick();
        n_vec++;
        if ({cdb_valid, p_rd} !== {1'b1, 6'd60}) begin
            n_bad++;
            $display("FAIL rstmid_pre: valid %b tag %0d want tag 60", cdb_valid, p_rd);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (cdb_all !== 45'd0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %h want 0", cdb_all);
        end
        #3 rst = 1'b1;
        tick();
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_lost: valid %b tag %0d want idle", cdb_valid, p_rd);
        end
        n_vec++;
        if (fu_ready !== 3'b111) begin
            n_bad++;
            $display("FAIL rstmid_ready: got %b want 111", fu_ready);
        end
        set_fu(0, 1'b1, 6'd0, 32'h70, 1'b1, 5'd10);
        set_fu(1, 1'b1, 6'd1, 32'h71, 1'b1, 5'd11);
        tick();
        fu_valid = '0;
        tick();
        n_vec++;
        if (cdb_all !== {2'b11, 6'd0, 32'h70, 5'd10}) begin
            n_bad++;
            $display("FAIL rstmid_rr0: got %h want %h", cdb_all, {2'b11, 6'd0, 32'h70, 5'd10});
        end
        tick();
        n_vec++;
        if ({cdb_valid, p_rd} !== {1'b1, 6'd1}) begin
            n_bad++;
            $display("FAIL rstmid_rr1: valid %b tag %0d want tag 1", cdb_valid, p_rd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_store();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
